// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcode constants,
// ALUOp encodings, FSM state enum and the decoded instruction class.
package ctrl_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BR   = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI  = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,  // LW/SW/JAL address or link arithmetic
    ALU_BR   = 2'b01,  // branch compare
    ALU_FUNC = 2'b10,  // R/I/JALR, function fields decide
    ALU_LUI  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR,
    CLS_LUI, CLS_JAL, CLS_JALR, CLS_HALT, CLS_ILL
  } instr_cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus EXEC-stage ALU controls.
// Ports: opcode in; cls, alu_src, alu_op out.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_cls_e          cls,
  output logic                alu_src,
  output alu_op_e             alu_op
);

  // Class lookup; anything not listed is illegal.
  always_comb begin
    cls = CLS_ILL;
    if      (opcode == OPCODE_W'(OP_R))    cls = CLS_R;
    else if (opcode == OPCODE_W'(OP_I))    cls = CLS_I;
    else if (opcode == OPCODE_W'(OP_LW))   cls = CLS_LW;
    else if (opcode == OPCODE_W'(OP_SW))   cls = CLS_SW;
    else if (opcode == OPCODE_W'(OP_BR))   cls = CLS_BR;
    else if (opcode == OPCODE_W'(OP_LUI))  cls = CLS_LUI;
    else if (opcode == OPCODE_W'(OP_JAL))  cls = CLS_JAL;
    else if (opcode == OPCODE_W'(OP_JALR)) cls = CLS_JALR;
    else if (opcode == OPCODE_W'(OP_HALT)) cls = CLS_HALT;
  end

  // Immediate operand select and ALU operation class.
  always_comb begin
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    case (cls)
      CLS_LW, CLS_SW: alu_src = 1'b1;
      CLS_I:    begin alu_src = 1'b1; alu_op = ALU_FUNC; end
      CLS_JALR: begin alu_src = 1'b1; alu_op = ALU_FUNC; end
      CLS_LUI:  begin alu_src = 1'b1; alu_op = ALU_LUI;  end
      CLS_R:    alu_op = ALU_FUNC;
      CLS_BR:   alu_op = ALU_BR;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALTED with a memory
// wait-timeout watchdog. Controls are decoded from state, opcode and
// mem_ready and forced to 0 while reset is high.
// Ports: clk, reset (async, active-high), Opcode, mem_ready in;
//   pc_write, ir_write, ALUSrc, MemtoReg, JaltoReg, JalrSel, Branch,
//   RegWrite, MemRead, MemWrite, ALUOp[2], Halt, mem_err, illegal, state[3] out.
// Option: CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                JaltoReg,
  output logic                JalrSel,
  output logic                Branch,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          ALUOp,
  output logic                Halt,
  output logic                mem_err,
  output logic                illegal,
  output logic [2:0]          state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  // wait_q only ever holds 0..WAIT_MAX-1.
  localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  if (WAIT_MAX < 1 || CNT_W < 1 || OPCODE_W < OPC_W) begin : g_param_check
    $error("multicycle_controller: invalid parameter values");
  end

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q;
  logic              timeout_c;

  instr_cls_e cls_c;
  logic       dec_alu_src_c;
  alu_op_e    dec_alu_op_c;

  logic    pc_write_c, ir_write_c, alu_src_c, mem_to_reg_c, jal_to_reg_c;
  logic    jalr_sel_c, branch_c, reg_write_c, mem_read_c, mem_write_c;
  logic    halt_c, illegal_c;
  alu_op_e alu_op_c;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode  (Opcode),
    .cls     (cls_c),
    .alu_src (dec_alu_src_c),
    .alu_op  (dec_alu_op_c)
  );

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout_c) mem_err_q <= 1'b1;
    end
  end

  // Next state and per-state controls.
  always_comb begin
    state_d      = state_q;
    timeout_c    = 1'b0;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    jal_to_reg_c = 1'b0;
    jalr_sel_c   = 1'b0;
    branch_c     = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    halt_c       = 1'b0;
    illegal_c    = 1'b0;
    alu_op_c     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_HALTED;
        end
      end
      S_DECODE: begin
        if (cls_c == CLS_HALT) begin
          state_d = S_HALTED;
        end else if (cls_c == CLS_ILL) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_c = dec_alu_src_c;
        alu_op_c  = dec_alu_op_c;
        case (cls_c)
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_BR: begin
            branch_c = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // Only LW/SW reach MEM, so anything not LW is a store.
        mem_read_c  = (cls_c == CLS_LW);
        mem_write_c = (cls_c != CLS_LW);
        if (mem_ready) begin
          state_d = (cls_c == CLS_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_HALTED;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (cls_c == CLS_LW);
        jal_to_reg_c = (cls_c == CLS_JAL) || (cls_c == CLS_JALR);
        jalr_sel_c   = (cls_c == CLS_JALR);
        state_d      = S_FETCH;
      end
      S_HALTED: halt_c = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

  // Count consecutive stalled cycles; any ready or state change restarts it.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && state_d == state_q)
      wait_d = wait_q + WAIT_W'(1);
  end

  assign pc_write = pc_write_c   & ~reset;
  assign ir_write = ir_write_c   & ~reset;
  assign ALUSrc   = alu_src_c    & ~reset;
  assign MemtoReg = mem_to_reg_c & ~reset;
  assign JaltoReg = jal_to_reg_c & ~reset;
  assign JalrSel  = jalr_sel_c   & ~reset;
  assign Branch   = branch_c     & ~reset;
  assign RegWrite = reg_write_c  & ~reset;
  assign MemRead  = mem_read_c   & ~reset;
  assign MemWrite = mem_write_c  & ~reset;
  assign ALUOp    = reset ? 2'b00 : alu_op_c;
  assign Halt     = halt_c       & ~reset;
  assign illegal  = illegal_c    & ~reset;
  assign mem_err  = mem_err_q;
  assign state    = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic retire_c;

  // An instruction retires when it returns to FETCH from EXEC, MEM or WB.
  assign retire_c = (state_d == S_FETCH) &&
                    (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_HALTED) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire_c)            instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;

  localparam logic [14:0] C_PCW   = 15'h4000;
  localparam logic [14:0] C_IRW   = 15'h2000;
  localparam logic [14:0] C_ASRC  = 15'h1000;
  localparam logic [14:0] C_MTR   = 15'h0800;
  localparam logic [14:0] C_JTR   = 15'h0400;
  localparam logic [14:0] C_JSEL  = 15'h0200;
  localparam logic [14:0] C_BR    = 15'h0100;
  localparam logic [14:0] C_RW    = 15'h0080;
  localparam logic [14:0] C_MR    = 15'h0040;
  localparam logic [14:0] C_MW    = 15'h0020;
  localparam logic [14:0] C_AOP10 = 15'h0010;
  localparam logic [14:0] C_AOP01 = 15'h0008;
  localparam logic [14:0] C_AOP11 = 15'h0018;
  localparam logic [14:0] C_HALT  = 15'h0004;
  localparam logic [14:0] C_MERR  = 15'h0002;
  localparam logic [14:0] C_ILL   = 15'h0001;
  localparam logic [14:0] C_FET   = C_MR | C_PCW | C_IRW;

  localparam logic [6:0] O_ADD  = 7'b0110011;
  localparam logic [6:0] O_ADDI = 7'b0010011;
  localparam logic [6:0] O_LW   = 7'b0000011;
  localparam logic [6:0] O_SW   = 7'b0100011;
  localparam logic [6:0] O_BEQ  = 7'b1100011;
  localparam logic [6:0] O_LUI  = 7'b0110111;
  localparam logic [6:0] O_JAL  = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111;
  localparam logic [6:0] O_HALT = 7'b1111111;
  localparam logic [6:0] O_BAD  = 7'b0000000;

  typedef struct {
    logic [6:0]  opc;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] Opcode = '0;
  logic mem_ready = 1'b0;
  logic pc_write, ir_write, ALUSrc, MemtoReg, JaltoReg, JalrSel, Branch;
  logic RegWrite, MemRead, MemWrite, Halt, mem_err, illegal;
  logic [1:0] ALUOp;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

  logic [14:0] ctl_act;
  assign ctl_act = {pc_write, ir_write, ALUSrc, MemtoReg, JaltoReg, JalrSel, Branch,
                    RegWrite, MemRead, MemWrite, ALUOp, Halt, mem_err, illegal};

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  multicycle_controller #(.OPCODE_W(7), .WAIT_MAX(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .JaltoReg(JaltoReg), .JalrSel(JalrSel), .Branch(Branch), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .Halt(Halt),
    .mem_err(mem_err), .illegal(illegal), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [6:0] o, logic r, logic [2:0] s, logic [14:0] c);
    vec_t v;
    v.opc = o; v.rdy = r; v.st = s; v.ctl = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] exp_st, input logic [14:0] exp_ctl);
    n_cmp++;
    if (state !== exp_st || ctl_act !== exp_ctl) begin
      n_err++;
      $display("FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h",
               name, state, ctl_act, exp_st, exp_ctl);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs right after posedge, check before the next posedge.
  task automatic step(input vec_t v, input string name);
    Opcode = v.opc;
    mem_ready = v.rdy;
    @(negedge clk);
    check(name, v.st, v.ctl);
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously, check outputs clear at once, release after posedge.
  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    check(name, 3'd0, 15'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [14:0] exec_ctl,
                           input logic [14:0] wb_ctl, input string name);
    step(mk(o, 1'b1, 3'd0, C_FET), name);
    step(mk(o, 1'b1, 3'd1, 15'h0), name);
    step(mk(o, 1'b1, 3'd2, exec_ctl), name);
    step(mk(o, 1'b1, 3'd4, wb_ctl), name);
  endtask

  initial begin
    // add: 0,1,2,4 with ALUOp=10 in EXEC and RegWrite only in WB
    vecs.push_back(mk(O_ADD, 1, 0, C_FET));
    vecs.push_back(mk(O_ADD, 1, 1, 15'h0));
    vecs.push_back(mk(O_ADD, 1, 2, C_AOP10));
    vecs.push_back(mk(O_ADD, 1, 4, C_RW));
    // lw with 3 MEM wait cycles: 8 cycles total
    vecs.push_back(mk(O_LW, 1, 0, C_FET));
    vecs.push_back(mk(O_LW, 1, 1, 15'h0));
    vecs.push_back(mk(O_LW, 1, 2, C_ASRC));
    vecs.push_back(mk(O_LW, 0, 3, C_MR));
    vecs.push_back(mk(O_LW, 0, 3, C_MR));
    vecs.push_back(mk(O_LW, 0, 3, C_MR));
    vecs.push_back(mk(O_LW, 1, 3, C_MR));
    vecs.push_back(mk(O_LW, 1, 4, C_RW | C_MTR));
    // beq: 3 cycles, Branch and ALUOp=01 in EXEC
    vecs.push_back(mk(O_BEQ, 1, 0, C_FET));
    vecs.push_back(mk(O_BEQ, 1, 1, 15'h0));
    vecs.push_back(mk(O_BEQ, 1, 2, C_BR | C_AOP01));
    // sw with zero-wait memory
    vecs.push_back(mk(O_SW, 1, 0, C_FET));
    vecs.push_back(mk(O_SW, 1, 1, 15'h0));
    vecs.push_back(mk(O_SW, 1, 2, C_ASRC));
    vecs.push_back(mk(O_SW, 1, 3, C_MW));
    // jal
    vecs.push_back(mk(O_JAL, 1, 0, C_FET));
    vecs.push_back(mk(O_JAL, 1, 1, 15'h0));
    vecs.push_back(mk(O_JAL, 1, 2, 15'h0));
    vecs.push_back(mk(O_JAL, 1, 4, C_RW | C_JTR));
    // jalr
    vecs.push_back(mk(O_JALR, 1, 0, C_FET));
    vecs.push_back(mk(O_JALR, 1, 1, 15'h0));
    vecs.push_back(mk(O_JALR, 1, 2, C_ASRC | C_AOP10));
    vecs.push_back(mk(O_JALR, 1, 4, C_RW | C_JTR | C_JSEL));
    // lui, with mem_ready low outside FETCH/MEM (ignored)
    vecs.push_back(mk(O_LUI, 1, 0, C_FET));
    vecs.push_back(mk(O_LUI, 0, 1, 15'h0));
    vecs.push_back(mk(O_LUI, 0, 2, C_ASRC | C_AOP11));
    vecs.push_back(mk(O_LUI, 0, 4, C_RW));
    // addi after a 2-cycle fetch stall
    vecs.push_back(mk(O_ADDI, 0, 0, C_MR));
    vecs.push_back(mk(O_ADDI, 0, 0, C_MR));
    vecs.push_back(mk(O_ADDI, 1, 0, C_FET));
    vecs.push_back(mk(O_ADDI, 1, 1, 15'h0));
    vecs.push_back(mk(O_ADDI, 1, 2, C_ASRC | C_AOP10));
    vecs.push_back(mk(O_ADDI, 1, 4, C_RW));
    // unknown opcode: illegal pulse in DECODE, straight back to FETCH
    vecs.push_back(mk(O_BAD, 1, 0, C_FET));
    vecs.push_back(mk(O_BAD, 1, 1, C_ILL));
    vecs.push_back(mk(O_BAD, 0, 0, C_MR));

    #1;
    do_reset("reset_initial");
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Fetch ready on the 15th wait cycle beats the timeout.
    do_reset("reset_edge");
    for (int i = 0; i < 14; i++) step(mk(O_ADD, 0, 0, C_MR), "edge_wait");
    step(mk(O_ADD, 1, 0, C_FET), "edge_ready");
    step(mk(O_ADD, 1, 1, 15'h0), "edge_decode");
    step(mk(O_ADD, 1, 2, C_AOP10), "edge_exec");
    step(mk(O_ADD, 1, 4, C_RW), "edge_wb");

    // 15 stalled fetch cycles: timeout, mem_err and Halt.
    for (int i = 0; i < 15; i++) step(mk(O_ADD, 0, 0, C_MR), "to_wait");
    for (int i = 0; i < 5; i++)
      step(mk(O_ADD, 1'(i % 2), 5, C_HALT | C_MERR), "to_halted");
    @(negedge clk);
    do_reset("reset_in_timeout_halt");
    step(mk(O_ADD, 0, 0, C_MR), "after_to_reset");

    // HALT opcode: sticky for 100 cycles, then reset from HALTED.
    do_reset("reset_pre_halt");
    step(mk(O_HALT, 1, 0, C_FET), "halt_fetch");
    step(mk(O_HALT, 1, 1, 15'h0), "halt_decode");
    for (int i = 0; i < 100; i++)
      step(mk(O_HALT, 1'(i % 2), 5, C_HALT), "halt_hold");
    @(negedge clk);
    do_reset("reset_in_halted");
    step(mk(O_ADD, 0, 0, C_MR), "after_halt_reset");

    // Reset in MEM during a store: write aborted, fresh FETCH after.
    do_reset("reset_pre_sw");
    step(mk(O_SW, 1, 0, C_FET), "sw_fetch");
    step(mk(O_SW, 1, 1, 15'h0), "sw_decode");
    step(mk(O_SW, 1, 2, C_ASRC), "sw_exec");
    step(mk(O_SW, 0, 3, C_MW), "sw_mem_wait");
    Opcode = O_SW;
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_mem_write", 3'd3, C_MW);
    do_reset("reset_in_mem");
    step(mk(O_SW, 0, 0, C_MR), "sw_refetch");
    step(mk(O_SW, 1, 0, C_FET), "sw_refetch_ready");
    step(mk(O_SW, 1, 1, 15'h0), "sw_refetch_decode");

`ifdef CTRL_PERF_CNT_EN
    do_reset("reset_pre_perf");
    check_val("perf_cycle_reset", int'(cycle_cnt), 0);
    check_val("perf_instr_reset", int'(instr_cnt), 0);
    for (int n = 0; n < 20; n++) begin
      alu_instr(O_ADD, C_AOP10, C_RW, "perf_add");
      if (n == 0) begin
        check_val("perf_cycle_one", int'(cycle_cnt), 4);
        check_val("perf_instr_one", int'(instr_cnt), 1);
      end
    end
    check_val("perf_instr_wrap", int'(instr_cnt), 4);
    check_val("perf_cycle_wrap", int'(cycle_cnt), 0);
`else
    do_reset("reset_pre_tail");
    alu_instr(O_ADD, C_AOP10, C_RW, "tail_add");
    check_val("tail_state", int'(state), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
